fpga_top: RTL and testbench
===========================

# fpga_top

Sixteen-node serial bus with a single shared wire. Each node has a local frame source: receiver address, 64-bit data word and 4-bit CRC. A node requests the bus through its bit of `mod`. Contending nodes are resolved by CAN-style wired-AND arbitration on the sender ID, and the winning frame is serialised onto `bus_show`. This is the top level of the bus demo; `bus_show` is its only observable output.

## Interface
Parameters:
- `NODES`, 16: number of nodes; the port list is fixed at 16.
- `EOF_BITS`, 7: number of recessive end-of-frame bits.

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `CRC1`..`CRC16`  in  4 each  CRC field of node i, transmitted verbatim.
- `Data1`..`Data16`  in  64 each  payload of node i.
- `receiverAddr1`..`receiverAddr16`  in  4 each  destination address of node i.
- `mod`  in  16  transmit-request vector; `mod[i-1]` = node i requests the bus.
- `bus_show`  out  1  registered serial bus level; 1 = recessive/idle, 0 = dominant.

## Operation
- Node i has sender ID i-1 (4 bits). Node 1 has ID 0 and the highest priority.
- Frame is 84 bits, every field MSB first:
  - SOF: 1 bit, 0.
  - Sender ID: 4 bits.
  - receiverAddr: 4 bits.
  - Data: 64 bits.
  - CRC: 4 bits.
  - EOF: 7 bits, all 1.
- States:
  - IDLE: bus = 1.
  - SOF, ID, RXADDR, DATA, CRC, EOF, each with a shared 7-bit bit counter.
- IDLE → SOF on a rising edge with `mod != 0`. At that edge, every requesting node latches its `receiverAddr`, `Data`, `CRC` and its `mod` bit.
- Arbitration during the ID field:
  - Each still-contending node drives its ID bit; all other nodes drive 1.
  - Bus = AND of all node drives.
  - A node that drives 1 and reads 0 withdraws for the rest of the frame.
  - Net effect: the lowest requesting index wins. Exactly one node remains after the ID field.
- RXADDR/DATA/CRC: only the winner drives; the bus equals the winner's latched bits.
- EOF → SOF when `mod != 0` on the last EOF bit (back-to-back frames). Otherwise EOF → IDLE.
- Losers are not queued. They compete again only if their `mod` bit is still set when the next frame starts.
- Changes to `mod`, `Data`, `CRC` or `receiverAddr` during a frame are ignored until the next SOF.
- No CRC is computed or checked; the CRC field is carried as data.

## Timing
- Reset: `bus_show` = 1, state IDLE, counter 0, all node latches cleared.
- Reset takes effect immediately, including mid-frame. The first frame may start on the first rising edge after `rst_n` rises.
- Latency: `mod` goes nonzero before edge k → SOF (0) appears on `bus_show` after edge k.
- Each frame occupies exactly 84 clock cycles.
- Bit position within a frame (b0 = SOF):
  - b1..b4 ID
  - b5..b8 receiverAddr
  - b9..b72 Data[63:0]
  - b73..b76 CRC
  - b77..b83 EOF
- Back-to-back frames: b0 of frame n+1 follows b83 of frame n with no gap.
- `mod = 0` in IDLE: `bus_show` stays 1 indefinitely.

## Structure
- Shared package `fpga_bus_pkg`:
  - Frame field widths: ID 4, ADDR 4, DATA 64, CRC 4, EOF 7.
  - Frame length 84.
  - State enum.
  - Field boundary constants.
- Sub-module `bus_node` instantiated 16 times. Each instance:
  - latches its frame at SOF;
  - drives its serial bit from the shared bit counter;
  - tracks its own "contending" flag from the bus readback.
- Top level holds the frame FSM and bit counter, ANDs the 16 node drives, and registers `bus_show`.

## Test plan
- Reset, then `mod`=0 for 50 cycles → `bus_show` constantly 1.
- `mod`=1, `Data1`=1, `CRC1`=1, `receiverAddr1`=1 → `bus_show` = 0, 0000, 0001, 63×0 then 1, 0001, 1111111 (84 bits).
- Immediately after that frame, `mod`=2, `Data2`=0, `CRC2`=1, `receiverAddr2`=2 → back-to-back frame 0, 0001, 0010, 64×0, 0001, 1111111. `mod`=0 during its EOF → IDLE with `bus_show`=1.
- `mod`=16'h0005 held → node 1 frame first (ID 0000), then node 3 frame (ID 0010) only if bit 0 is cleared before the next SOF. With bit 0 still set, node 1 wins again.
- During a node-1 frame, change `Data1` and set `mod`=16'h0000 → the current frame completes with the latched data, then IDLE.
- Assert `rst_n`=0 at b40 of a frame → `bus_show`=1 immediately. After release with `mod`=1, a fresh 84-bit frame starts.

Source files
------------

// File: rtl/fpga_bus_pkg.sv
// Shared frame layout, FSM states and bit-position helpers for the 16-node serial bus.
package fpga_bus_pkg;

  localparam int ID_W      = 4;
  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 64;
  localparam int CRC_W     = 4;
  localparam int EOF_W     = 7;
  localparam int FRAME_LEN = 1 + ID_W + ADDR_W + DATA_W + CRC_W + EOF_W;
  localparam int CNT_W     = 7;

  // First bit index of each field; b0 is always SOF.
  localparam logic [CNT_W-1:0] ID_FIRST   = 7'd1;
  localparam logic [CNT_W-1:0] ADDR_FIRST = ID_FIRST + 7'(ID_W);
  localparam logic [CNT_W-1:0] DATA_FIRST = ADDR_FIRST + 7'(ADDR_W);
  localparam logic [CNT_W-1:0] CRC_FIRST  = DATA_FIRST + 7'(DATA_W);
  localparam logic [CNT_W-1:0] EOF_FIRST  = CRC_FIRST + 7'(CRC_W);
  localparam logic [CNT_W-1:0] LAST_BIT   = 7'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_ID,
    ST_RXADDR,
    ST_DATA,
    ST_CRC,
    ST_EOF
  } busState_e;

  function automatic busState_e stateOf(input logic [CNT_W-1:0] bitIdx);
    if (bitIdx < ID_FIRST)        return ST_SOF;
    else if (bitIdx < ADDR_FIRST) return ST_ID;
    else if (bitIdx < DATA_FIRST) return ST_RXADDR;
    else if (bitIdx < CRC_FIRST)  return ST_DATA;
    else if (bitIdx < EOF_FIRST)  return ST_CRC;
    else                          return ST_EOF;
  endfunction

endpackage

// File: rtl/fpga_top_node.sv
// One bus node: latches its frame at SOF, drives the bit for the upcoming position
// and drops out of arbitration when it sends recessive but the bus reads dominant.
module bus_node
  import fpga_bus_pkg::*;
#(
  parameter logic [ID_W-1:0] NODE_ID = '0
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_data,
  input  logic [CRC_W-1:0]    i_crc,
  input  busState_e           i_nextState,
  input  logic [CNT_W-1:0]    i_nextCnt,
  input  logic                i_busNext,
  output logic                o_drive
);

  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_data;
  logic [CRC_W-1:0]     r_crc;
  logic                 r_contend;
  logic [FRAME_LEN-1:0] w_frame;

  assign w_frame = {1'b0, NODE_ID, r_addr, r_data, r_crc, {EOF_W{1'b1}}};

  // Drives always look one bit ahead so the top can register the bus level.
  always_comb begin
    o_drive = 1'b1;
    if (r_contend) begin
      case (i_nextState)
        ST_ID, ST_RXADDR, ST_DATA, ST_CRC: o_drive = w_frame[LAST_BIT - i_nextCnt];
        default: o_drive = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_data    <= '0;
      r_crc     <= '0;
      r_contend <= 1'b0;
    end else if (i_start) begin
      r_contend <= i_req;
      if (i_req) begin
        r_addr <= i_addr;
        r_data <= i_data;
        r_crc  <= i_crc;
      end
    end else if (i_nextState == ST_ID && r_contend && o_drive && !i_busNext) begin
      r_contend <= 1'b0;
    end
  end

endmodule

// File: rtl/fpga_top.sv
// Top of the bus demo: frame FSM and shared bit counter, wired-AND of the node drives,
// and the registered bus level.
module fpga_top
  import fpga_bus_pkg::*;
#(
  parameter int NODES    = 16,
  parameter int EOF_BITS = 7
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic [3:0]  CRC1,  CRC2,  CRC3,  CRC4,  CRC5,  CRC6,  CRC7,  CRC8,
  input  logic [3:0]  CRC9,  CRC10, CRC11, CRC12, CRC13, CRC14, CRC15, CRC16,
  input  logic [63:0] Data1,  Data2,  Data3,  Data4,  Data5,  Data6,  Data7,  Data8,
  input  logic [63:0] Data9,  Data10, Data11, Data12, Data13, Data14, Data15, Data16,
  input  logic [3:0]  receiverAddr1,  receiverAddr2,  receiverAddr3,  receiverAddr4,
  input  logic [3:0]  receiverAddr5,  receiverAddr6,  receiverAddr7,  receiverAddr8,
  input  logic [3:0]  receiverAddr9,  receiverAddr10, receiverAddr11, receiverAddr12,
  input  logic [3:0]  receiverAddr13, receiverAddr14, receiverAddr15, receiverAddr16,
  input  logic [15:0] mod,
  output logic        bus_show
);

  localparam logic [CNT_W-1:0] FRAME_LAST = EOF_FIRST + 7'(EOF_BITS - 1);

  busState_e          r_state;
  busState_e          w_nextState;
  logic [CNT_W-1:0]   r_bitCnt;
  logic [CNT_W-1:0]   w_nextCnt;
  logic               w_start;
  logic               w_busNext;
  logic               r_busShow;
  logic [NODES-1:0]   w_drive;
  logic [CRC_W-1:0]   w_crc  [NODES];
  logic [DATA_W-1:0]  w_data [NODES];
  logic [ADDR_W-1:0]  w_addr [NODES];

  assign w_crc[0]  = CRC1;   assign w_crc[1]  = CRC2;   assign w_crc[2]  = CRC3;   assign w_crc[3]  = CRC4;
  assign w_crc[4]  = CRC5;   assign w_crc[5]  = CRC6;   assign w_crc[6]  = CRC7;   assign w_crc[7]  = CRC8;
  assign w_crc[8]  = CRC9;   assign w_crc[9]  = CRC10;  assign w_crc[10] = CRC11;  assign w_crc[11] = CRC12;
  assign w_crc[12] = CRC13;  assign w_crc[13] = CRC14;  assign w_crc[14] = CRC15;  assign w_crc[15] = CRC16;

  assign w_data[0]  = Data1;   assign w_data[1]  = Data2;   assign w_data[2]  = Data3;   assign w_data[3]  = Data4;
  assign w_data[4]  = Data5;   assign w_data[5]  = Data6;   assign w_data[6]  = Data7;   assign w_data[7]  = Data8;
  assign w_data[8]  = Data9;   assign w_data[9]  = Data10;  assign w_data[10] = Data11;  assign w_data[11] = Data12;
  assign w_data[12] = Data13;  assign w_data[13] = Data14;  assign w_data[14] = Data15;  assign w_data[15] = Data16;

  assign w_addr[0]  = receiverAddr1;   assign w_addr[1]  = receiverAddr2;
  assign w_addr[2]  = receiverAddr3;   assign w_addr[3]  = receiverAddr4;
  assign w_addr[4]  = receiverAddr5;   assign w_addr[5]  = receiverAddr6;
  assign w_addr[6]  = receiverAddr7;   assign w_addr[7]  = receiverAddr8;
  assign w_addr[8]  = receiverAddr9;   assign w_addr[9]  = receiverAddr10;
  assign w_addr[10] = receiverAddr11;  assign w_addr[11] = receiverAddr12;
  assign w_addr[12] = receiverAddr13;  assign w_addr[13] = receiverAddr14;
  assign w_addr[14] = receiverAddr15;  assign w_addr[15] = receiverAddr16;

  // A new frame starts from IDLE or straight out of the last EOF bit.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_bitCnt;
    w_start     = 1'b0;
    if (r_state == ST_IDLE || r_bitCnt == FRAME_LAST) begin
      w_nextCnt = '0;
      if (mod != '0) begin
        w_nextState = ST_SOF;
        w_start     = 1'b1;
      end else begin
        w_nextState = ST_IDLE;
      end
    end else begin
      w_nextCnt   = r_bitCnt + 7'd1;
      w_nextState = stateOf(w_nextCnt);
    end
  end

  assign w_busNext = (w_nextState == ST_SOF) ? 1'b0 : &w_drive;

  for (genvar g = 0; g < NODES; g++) begin : gNode
    bus_node #(
      .NODE_ID(4'(g))
    ) uNode (
      .clock       (clock),
      .rst_n       (rst_n),
      .i_start     (w_start),
      .i_req       (mod[g]),
      .i_addr      (w_addr[g]),
      .i_data      (w_data[g]),
      .i_crc       (w_crc[g]),
      .i_nextState (w_nextState),
      .i_nextCnt   (w_nextCnt),
      .i_busNext   (w_busNext),
      .o_drive     (w_drive[g])
    );
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_bitCnt  <= '0;
      r_busShow <= 1'b1;
    end else begin
      r_state   <= w_nextState;
      r_bitCnt  <= w_nextCnt;
      r_busShow <= w_busNext;
    end
  end

  assign bus_show = r_busShow;

endmodule

// File: tb/tb_fpga_top.sv
// Self-checking bench for fpga_top: a queue of expected bus bits is filled with a whole
// frame whenever a frame starts, built from the lowest requesting node's inputs.
module tb_fpga_top;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] mod   = '0;
  logic [3:0]  crc  [16];
  logic [63:0] data [16];
  logic [3:0]  addr [16];
  logic        bus_show;

  int          total = 0;
  int          bad   = 0;
  logic        modelQ[$];
  logic [83:0] cap = '0;

  always #5 clock = ~clock;

  fpga_top #(.NODES(16), .EOF_BITS(7)) dut (
    .clock(clock), .rst_n(rst_n),
    .CRC1(crc[0]),   .CRC2(crc[1]),   .CRC3(crc[2]),   .CRC4(crc[3]),
    .CRC5(crc[4]),   .CRC6(crc[5]),   .CRC7(crc[6]),   .CRC8(crc[7]),
    .CRC9(crc[8]),   .CRC10(crc[9]),  .CRC11(crc[10]), .CRC12(crc[11]),
    .CRC13(crc[12]), .CRC14(crc[13]), .CRC15(crc[14]), .CRC16(crc[15]),
    .Data1(data[0]),   .Data2(data[1]),   .Data3(data[2]),   .Data4(data[3]),
    .Data5(data[4]),   .Data6(data[5]),   .Data7(data[6]),   .Data8(data[7]),
    .Data9(data[8]),   .Data10(data[9]),  .Data11(data[10]), .Data12(data[11]),
    .Data13(data[12]), .Data14(data[13]), .Data15(data[14]), .Data16(data[15]),
    .receiverAddr1(addr[0]),   .receiverAddr2(addr[1]),   .receiverAddr3(addr[2]),
    .receiverAddr4(addr[3]),   .receiverAddr5(addr[4]),   .receiverAddr6(addr[5]),
    .receiverAddr7(addr[6]),   .receiverAddr8(addr[7]),   .receiverAddr9(addr[8]),
    .receiverAddr10(addr[9]),  .receiverAddr11(addr[10]), .receiverAddr12(addr[11]),
    .receiverAddr13(addr[12]), .receiverAddr14(addr[13]), .receiverAddr15(addr[14]),
    .receiverAddr16(addr[15]),
    .mod(mod),
    .bus_show(bus_show)
  );

  task automatic checkOutput(input string tag, input logic expected);
    total++;
    assert (bus_show === expected) else begin
      bad++;
      $error("[TB] FAIL %s: bus_show=%b expected=%b at %0t", tag, bus_show, expected, $time);
    end
  endtask

  task automatic checkFrame(input string tag, input logic [83:0] expected);
    total++;
    assert (cap === expected) else begin
      bad++;
      $error("[TB] FAIL %s: frame=%h expected=%h", tag, cap, expected);
    end
  endtask

  // The lowest set bit of mod wins arbitration; its frame is queued bit by bit.
  task automatic buildFrame();
    int          winner;
    logic [83:0] f;
    winner = -1;
    for (int i = 15; i >= 0; i--) if (mod[i]) winner = i;
    f = {1'b0, 4'(winner), addr[winner], data[winner], crc[winner], 7'h7F};
    for (int k = 83; k >= 0; k--) modelQ.push_back(f[k]);
  endtask

  task automatic applyStimulus(input string tag);
    logic expected;
    if (modelQ.size() == 0 && mod != '0) buildFrame();
    expected = (modelQ.size() != 0) ? modelQ.pop_front() : 1'b1;
    @(posedge clock);
    #1;
    cap = {cap[82:0], bus_show};
    checkOutput(tag, expected);
  endtask

  task automatic randomizeNodes();
    for (int i = 0; i < 16; i++) begin
      data[i] = {$urandom, $urandom};
      crc[i]  = 4'($urandom);
      addr[i] = 4'($urandom);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      data[i] = '0;
      crc[i]  = '0;
      addr[i] = '0;
    end
    #12;
    checkOutput("reset", 1'b1);
    @(negedge clock);
    rst_n = 1'b1;

    repeat (50) applyStimulus("idle");

    data[0] = 64'h1; crc[0] = 4'h1; addr[0] = 4'h1; mod = 16'h0001;
    applyStimulus("frame1");
    mod = '0;
    repeat (83) applyStimulus("frame1");
    checkFrame("frame1Bits", {1'b0, 4'h0, 4'h1, 64'h1, 4'h1, 7'h7F});

    data[1] = 64'h0; crc[1] = 4'h1; addr[1] = 4'h2; mod = 16'h0002;
    applyStimulus("frame2");
    mod = '0;
    repeat (83) applyStimulus("frame2");
    checkFrame("frame2Bits", {1'b0, 4'h1, 4'h2, 64'h0, 4'h1, 7'h7F});
    repeat (10) applyStimulus("idleAfter2");

    randomizeNodes();
    mod = 16'h0005;
    repeat (168) applyStimulus("arbHeld");
    mod = 16'h0004;
    repeat (84) applyStimulus("arbNode3");
    mod = '0;
    repeat (10) applyStimulus("arbIdle");

    repeat (700) begin
      randomizeNodes();
      mod = ($urandom_range(0, 3) == 0) ? 16'($urandom) : ($urandom_range(0, 1) == 0 ? 16'h0000 : 16'h8000);
      applyStimulus("random");
    end
    mod = '0;
    repeat (90) applyStimulus("drain");

    data[0] = 64'hAAAA_5555_F0F0_0F0F; mod = 16'h0001;
    applyStimulus("latchHold");
    data[0] = ~data[0]; crc[0] = ~crc[0]; addr[0] = ~addr[0]; mod = '0;
    repeat (83) applyStimulus("latchHold");
    repeat (5) applyStimulus("latchIdle");

    data[0] = '0; crc[0] = '0; addr[0] = '0; mod = 16'h0001;
    applyStimulus("preReset");
    mod = '0;
    repeat (40) applyStimulus("preReset");
    rst_n = 1'b0;
    #1;
    checkOutput("resetMid", 1'b1);
    modelQ.delete();
    @(negedge clock);
    rst_n = 1'b1;
    data[0] = {$urandom, $urandom}; mod = 16'h0001;
    applyStimulus("postReset");
    mod = '0;
    repeat (83) applyStimulus("postReset");
    repeat (5) applyStimulus("postIdle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
